// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token and a per-grant hold limit.
// Handshake: a requester holds req[i] high. gnt[i] rises one edge later and stays high
// until done[i], a dropped req[i], or the hold limit. At least one idle cycle follows each grant.
module ring_rr_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] done,
   output logic [WIDTH-1:0] gnt,
   output logic [WIDTH-1:0] token,
   output logic             busy,
   output logic             timeout,
   output logic             dbg_state
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] gnt_n, token_n;
   logic [CW-1:0]    hold_cnt, hold_n;
   logic             timeout_n;

   logic [WIDTH-1:0] hi_req, pick_src, sel, rot;
   logic             owner_done, owner_req, hold_hit;

   // Circular search from the token: prefer requests at or above the token bit,
   // otherwise wrap to the lowest set request. x & -x isolates the lowest set bit.
   assign hi_req   = req & ~(token - WIDTH'(1));
   assign pick_src = (|hi_req) ? hi_req : req;
   assign sel      = pick_src & (~pick_src + WIDTH'(1));

   generate
      if (WIDTH == 1) begin : g_rot1
         assign rot = gnt;
      end else begin : g_rotn
         assign rot = {gnt[WIDTH-2:0], gnt[WIDTH-1]};
      end
   endgenerate

   assign owner_done = |(done & gnt);
   assign owner_req  = |(req & gnt);
   assign hold_hit   = (hold_cnt == HOLD_LAST);

   always_comb begin
      state_n   = state;
      gnt_n     = gnt;
      token_n   = token;
      hold_n    = hold_cnt;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            gnt_n = '0;
            if (|req) begin
               gnt_n   = sel;
               hold_n  = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (owner_done || !owner_req || hold_hit) begin
               gnt_n     = '0;
               token_n   = rot;
               state_n   = IDLE;
               // A forced release is flagged only when the owner still wanted the resource.
               timeout_n = hold_hit && !owner_done && owner_req;
            end else begin
               hold_n = hold_cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         gnt      <= '0;
         token    <= WIDTH'(1);
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         token    <= token_n;
         hold_cnt <= hold_n;
         timeout  <= timeout_n;
      end
   end

   assign busy      = (state == GRANT);
   assign dbg_state = state;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter: the driver pushes per-cycle expected outputs,
// a monitor pops and compares them at the falling edge (or on demand for async reset).
module tb_ring_rr_arbiter;

   localparam int W  = 4;
   localparam int EW = 11;

   logic         clk;
   logic         rstn;
   logic [W-1:0] req, done;
   logic [W-1:0] gnt, token;
   logic         busy, timeout, dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_v, act_v;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_step   = 0;
   event          mon_ev;

   ring_rr_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .token    (token),
      .busy     (busy),
      .timeout  (timeout),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: inputs set at the falling edge, expectation pushed just after the rising edge
   task automatic step(input logic [W-1:0] r, input logic [W-1:0] d,
                       input logic [W-1:0] eg, input logic [W-1:0] et, input logic etmo);
      @(negedge clk);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
      n_step++;
      exp_q.push_back({eg, et, |eg, etmo, |eg});
   endtask

   // asynchronous reset pulse placed between edges and checked without any clock edge
   task automatic reset_pulse();
      @(negedge clk);
      req  = '0;
      done = '0;
      #2 rstn = 1'b0;
      #1;
      n_step++;
      exp_q.push_back({4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0});
      ->mon_ev;
      #1 rstn = 1'b1;
   endtask

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk or mon_ev);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {gnt, token, busy, timeout, dbg_state};
            n_checks++;
            if (act_v !== exp_v)  begin
               n_fail++;
               $display("FAIL step%0d gnt/token/busy/timeout/state: got %b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                        n_step, act_v[10:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                        exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
            end
         end
      end
   end

   // stimulus
   initial begin
      logic [W-1:0] g, nxt;
      rstn = 1'b0;
      req  = '0;
      done = '0;

      // reset held over two edges with every line requesting
      step(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      step(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      rstn = 1'b1;

      // starvation bound: each owner keeps req and never signals done
      for (int n = 0; n < 4; n++) begin
         g   = 4'b0001 << n;
         nxt = (n == 3) ? 4'b0001 : (4'b0001 << (n + 1));
         repeat (8) step(4'b1111, 4'b0000, g, g, 1'b0);
         step(4'b1111, 4'b0000, 4'b0000, nxt, 1'b1);
      end

      // alternating pair with done two cycles into each grant
      step(4'b0101, 4'b0000, 4'b0001, 4'b0001, 1'b0);
      step(4'b0101, 4'b0000, 4'b0001, 4'b0001, 1'b0);
      step(4'b0101, 4'b0001, 4'b0000, 4'b0010, 1'b0);
      step(4'b0101, 4'b0000, 4'b0100, 4'b0010, 1'b0);
      step(4'b0101, 4'b0000, 4'b0100, 4'b0010, 1'b0);
      step(4'b0101, 4'b0100, 4'b0000, 4'b1000, 1'b0);
      step(4'b0101, 4'b0000, 4'b0001, 4'b1000, 1'b0);
      step(4'b0101, 4'b0100, 4'b0001, 4'b1000, 1'b0);
      step(4'b0101, 4'b0001, 4'b0000, 4'b0010, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);

      // early release by dropped req, ignored non-owner done
      step(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
      step(4'b0010, 4'b0001, 4'b0010, 4'b0010, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0);

      // done coinciding with the hold limit is a normal release
      step(4'b0010, 4'b0000, 4'b0010, 4'b0100, 1'b0);
      repeat (7) step(4'b0010, 4'b0000, 4'b0010, 4'b0100, 1'b0);
      step(4'b0010, 4'b0010, 4'b0000, 4'b0100, 1'b0);

      // wrap of the token and of the search
      step(4'b1000, 4'b0000, 4'b1000, 4'b0100, 1'b0);
      step(4'b1000, 4'b1000, 4'b0000, 4'b0001, 1'b0);
      step(4'b1000, 4'b0000, 4'b1000, 4'b0001, 1'b0);
      step(4'b1000, 4'b1000, 4'b0000, 4'b0001, 1'b0);
      step(4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b0);

      // reset in the middle of a grant at hold_cnt = 3
      step(4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b0);
      repeat (3) step(4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b0);
      reset_pulse();
      step(4'b0100, 4'b0000, 4'b0100, 4'b0001, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0);

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
